vector_output_serializer: RTL and testbench
===========================================

// Module: vector_output_serializer
// PURPOSE
//  Downstream consumer of the CPU's memory-stage result port (out bus + outFlag).
//  Captures each flagged VECTOR_SIZE*DATA_WIDTH result into a small FIFO.
//  Replays every captured vector one element per beat on a valid/ready stream
//  for the display/UART sink, so a slow sink never stalls or loses CPU output
//  while buffer space remains.
// PARAMETERS
//  DATA_WIDTH   16  width of one vector element
//  VECTOR_SIZE  6   elements per vector
//  FIFO_DEPTH   4   vectors buffered; power of two, >=2
// PORTS
//  clock         in   1                       single system clock, rising edge
//  reset         in   1                       asynchronous, active-low (0 = reset)
//  vectorIn      in   VECTOR_SIZE*DATA_WIDTH  CPU out bus; element k = bits [k*DATA_WIDTH +: DATA_WIDTH]
//  vectorValid   in   1                       CPU outFlag; each high cycle = one vector
//  elementData   out  DATA_WIDTH              current element
//  elementValid  out  1                       elementData valid
//  elementReady  in   1                       sink accepts the beat
//  elementIndex  out  $clog2(VECTOR_SIZE)     index of current element
//  elementLast   out  1                       high on index VECTOR_SIZE-1
//  fifoCount     out  $clog2(FIFO_DEPTH)+1    vectors waiting in FIFO (excludes hold reg)
//  overflow      out  1                       sticky: a vector was dropped
//  clearOverflow in   1                       sync clear of overflow
//  busy          out  1                       state!=IDLE || fifoCount!=0
// BEHAVIOUR
//  - Reset (async, immediate): FIFO empty, state IDLE, hold reg 0, index 0.
//    All outputs 0. An in-flight vector is discarded, with no partial completion.
//  - Push on edge where vectorValid=1 and (fifoCount<FIFO_DEPTH or pop in same cycle).
//  - Push when full with no pop: vector dropped, overflow<=1.
//    Overflow set has priority over clearOverflow in the same cycle.
//  - FSM states IDLE, SEND:
//    IDLE: fifo non-empty -> pop head into hold reg, index<=0, ->SEND.
//    SEND: elementValid=1; elementData=hold[index].
//      - fire (valid&ready), index<VECTOR_SIZE-1: index++.
//      - fire on last element, fifo non-empty: pop next into hold, index<=0,
//        stay SEND (no bubble).
//      - fire on last element, fifo empty: ->IDLE.
//  - Data, index and last are stable while elementValid && !elementReady.
//    Elements are never skipped or duplicated.
//  - Latency: vectorValid high at edge N -> elementValid high after edge N+1
//    (2 cycles). Throughput is 1 element/cycle.
//  - Simultaneous push and pop at full: both occur, fifoCount unchanged.
//  - Push into empty FIFO while IDLE: popped on next edge (no same-cycle bypass).
//  - Pointers wrap modulo FIFO_DEPTH. fifoCount saturates at FIFO_DEPTH by construction.
// STRUCTURE
//  - Package vector_io_pkg: typedef element_t (logic [DATA_WIDTH-1:0]),
//    typedef enum {IDLE,SEND} ser_state_t, and localparam widths.
//  - Sub-module vector_fifo: sync FIFO, FIFO_DEPTH x VECTOR_SIZE*DATA_WIDTH.
//    Provides push/pop, full/empty and count; async active-low reset on pointers/count.
//  - Top level holds the FSM, hold register, index counter and overflow flag.
// TESTING
//  1. Reset low, then high, idle -> elementValid=0, fifoCount=0, overflow=0, busy=0.
//  2. One vector: elements 0..5 = 0x0000..0x0005, ready=1.
//     -> elementValid 2 cycles later; data 0,1,2,3,4,5 on 6 consecutive cycles.
//     -> elementLast only with 5; then busy=0.
//  3. Same vector, ready pattern 1,0,0,1,1,0,1,1.
//     -> data/index held through ready=0; exact sequence 0..5 observed.
//  4. Vectors A (0x0A0..0x0A5) and B (0x0B0..0x0B5) on consecutive cycles, ready=1.
//     -> 12 consecutive beats A0..A5,B0..B5, no bubble between A5 and B0.
//  5. ready=0, six vectors pushed on consecutive cycles.
//     -> 1st in hold, next 4 in FIFO (fifoCount=4), 6th dropped, overflow=1.
//     -> pulse clearOverflow -> overflow=0.
//     -> ready=1 -> exactly 5 vectors (30 beats) emerge, in order.
//  6. Reset asserted mid-vector at index 2.
//     -> elementValid=0 and fifoCount=0 immediately.
//     -> after release, a new vector streams from index 0.

Source files
------------

// File: rtl/vector_io_pkg.sv
// ---------------------------------------------------------------------------
// vector_io_pkg
// Shared types and default sizes for the vector output serializer slice.
//   element_t    : one vector element at the default element width
//   ser_state_t  : serializer FSM state (IDLE, SEND)
//   VIO_*        : default parameter values used by the top level
//   vio_cnt_w()  : width of an occupancy counter able to hold 0..depth
// ---------------------------------------------------------------------------
package vector_io_pkg;

  localparam int VIO_DATA_WIDTH  = 16;
  localparam int VIO_VECTOR_SIZE = 6;
  localparam int VIO_FIFO_DEPTH  = 4;

  typedef logic [VIO_DATA_WIDTH-1:0] element_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // A counter covering 0..depth inclusive needs one bit more than the pointer.
  function automatic int vio_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vector_fifo.sv
// ---------------------------------------------------------------------------
// vector_fifo
// Synchronous FIFO holding whole vectors (one entry = one CPU result).
// Ports:
//   i_clk    : rising-edge clock
//   i_rst_n  : asynchronous active-low reset (pointers and count only)
//   i_push   : write i_data this edge (accepted if not full, or popping)
//   i_data   : vector to store
//   i_pop    : remove head this edge (ignored when empty)
//   o_data   : current head entry (valid when !o_empty)
//   o_full   : DEPTH entries stored
//   o_empty  : no entries stored
//   o_count  : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module vector_fifo
  import vector_io_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_data,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [vio_cnt_w(DEPTH)-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = vio_cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A push into a full FIFO is still legal when the head leaves the same edge.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage carries no reset; only entries below r_count are ever observed.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vector_output_serializer.sv
// ---------------------------------------------------------------------------
// vector_output_serializer
// Buffers flagged CPU result vectors and replays each one element per beat
// on a valid/ready stream, so a slow sink never stalls the CPU while FIFO
// space remains.
// Ports:
//   clock         : rising-edge system clock
//   reset         : asynchronous active-low reset
//   vectorIn      : CPU result bus, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   vectorValid   : one vector offered per high cycle
//   elementData   : element currently presented
//   elementValid  : elementData is valid
//   elementReady  : sink accepts the current beat
//   elementIndex  : index of the presented element within its vector
//   elementLast   : presented element is the final one of its vector
//   fifoCount     : vectors waiting in the FIFO (hold register excluded)
//   overflow      : sticky, a vector arrived while the FIFO was full
//   clearOverflow : synchronous clear of overflow
//   busy          : a vector is being sent or is waiting
// VECTOR_SIZE must be at least 2; FIFO_DEPTH a power of two, at least 2.
// ---------------------------------------------------------------------------
module vector_output_serializer
  import vector_io_pkg::*;
#(
  parameter int DATA_WIDTH  = VIO_DATA_WIDTH,
  parameter int VECTOR_SIZE = VIO_VECTOR_SIZE,
  parameter int FIFO_DEPTH  = VIO_FIFO_DEPTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [VECTOR_SIZE*DATA_WIDTH-1:0]  vectorIn,
  input  logic                               vectorValid,
  output logic [DATA_WIDTH-1:0]              elementData,
  output logic                               elementValid,
  input  logic                               elementReady,
  output logic [$clog2(VECTOR_SIZE)-1:0]     elementIndex,
  output logic                               elementLast,
  output logic [vio_cnt_w(FIFO_DEPTH)-1:0]   fifoCount,
  output logic                               overflow,
  input  logic                               clearOverflow,
  output logic                               busy
);

  localparam int VEC_W = VECTOR_SIZE * DATA_WIDTH;
  localparam int IDX_W = $clog2(VECTOR_SIZE);
  localparam int CNT_W = vio_cnt_w(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [VEC_W-1:0] r_hold;
  logic [IDX_W-1:0] r_index;
  logic             r_overflow;

  logic [VEC_W-1:0]      w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic                  w_fire;
  logic                  w_at_last;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [DATA_WIDTH-1:0] w_elem;

  vector_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_data  (vectorIn),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_at_last = (r_index == LAST_IDX);
  assign w_fire    = (r_state == SEND) && elementReady;

  // A full FIFO still takes the new vector when the head moves to hold now.
  assign w_push = vectorValid && (!w_full || w_pop);
  assign w_drop = vectorValid && w_full && !w_pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        // Back-to-back vectors: reload hold on the last beat, no idle cycle.
        if (w_fire && w_at_last) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Hold register and index only move on a pop or an accepted beat, which
  // keeps data/index/last frozen while the sink stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold  <= '0;
      r_index <= '0;
    end else if (w_pop) begin
      r_hold  <= w_head;
      r_index <= '0;
    end else if (w_fire) begin
      r_index <= w_at_last ? '0 : r_index + IDX_W'(1);
    end
  end

  // Drop detection wins over a same-cycle clear so no loss goes unreported.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clearOverflow) begin
      r_overflow <= 1'b0;
    end
  end

  // Element mux written with constant slices only.
  always_comb begin
    w_elem = '0;
    for (int k = 0; k < VECTOR_SIZE; k++) begin
      if (r_index == IDX_W'(k)) begin
        w_elem = r_hold[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign elementData  = w_elem;
  assign elementValid = (r_state == SEND);
  assign elementIndex = r_index;
  assign elementLast  = (r_state == SEND) && w_at_last;
  assign fifoCount    = w_count;
  assign overflow     = r_overflow;
  assign busy         = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_vector_output_serializer.sv
// ---------------------------------------------------------------------------
// tb_vector_output_serializer
// Directed bench: each vector driven also queues its six expected beats;
// every cycle the presented element is compared with the queue head, which
// is popped when the sink accepts it.
// ---------------------------------------------------------------------------
module tb_vector_output_serializer;
  import vector_io_pkg::*;

  localparam int DW = 16;
  localparam int VS = 6;
  localparam int FD = 4;
  localparam int VW = DW * VS;

  logic           clock;
  logic           reset;
  logic [VW-1:0]  vectorIn;
  logic           vectorValid;
  logic [DW-1:0]  elementData;
  logic           elementValid;
  logic           elementReady;
  logic [2:0]     elementIndex;
  logic           elementLast;
  logic [2:0]     fifoCount;
  logic           overflow;
  logic           clearOverflow;
  logic           busy;

  vector_output_serializer #(
    .DATA_WIDTH  (DW),
    .VECTOR_SIZE (VS),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .vectorIn      (vectorIn),
    .vectorValid   (vectorValid),
    .elementData   (elementData),
    .elementValid  (elementValid),
    .elementReady  (elementReady),
    .elementIndex  (elementIndex),
    .elementLast   (elementLast),
    .fifoCount     (fifoCount),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    element_t   d;
    logic [2:0] i;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   beats    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [15:0] base);
    logic [VW-1:0] v;
    for (int k = 0; k < VS; k++) v[k*DW +: DW] = base + 16'(k);
    return v;
  endfunction

  task automatic push_exp(input logic [15:0] base);
    exp_t e;
    for (int k = 0; k < VS; k++) begin
      e.d = base + 16'(k);
      e.i = 3'(k);
      e.l = (k == VS - 1);
      q.push_back(e);
    end
  endtask

  // Compare the presented element with the scoreboard head; consume on accept.
  task automatic check_beat();
    exp_t e;
    if (elementValid) begin
      if (q.size() == 0) begin
        chk("valid_without_expected_beat", 32'(elementValid), 32'd0);
      end else begin
        e = q[0];
        chk("data",  32'(elementData),  32'(e.d));
        chk("index", 32'(elementIndex), 32'(e.i));
        chk("last",  32'(elementLast),  32'(e.l));
        if (elementReady) begin
          e = q.pop_front();
          beats++;
        end
      end
    end
  endtask

  task automatic cyc(input logic rdy, input logic vv, input logic [VW-1:0] vec, input logic clr);
    @(negedge clock);
    elementReady  = rdy;
    vectorValid   = vv;
    vectorIn      = vec;
    clearOverflow = clr;
    #1;
    check_beat();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(rdy, 1'b0, '0, 1'b0);
  endtask

  task automatic send(input logic [15:0] base, input logic rdy, input logic keep);
    if (keep) push_exp(base);
    cyc(rdy, 1'b1, mkvec(base), 1'b0);
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (q.size() != 0 && c < maxc) begin
      cyc(1'b1, 1'b0, '0, 1'b0);
      c++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;
    int         bubbles;
    bit         found;

    reset         = 1'b0;
    vectorValid   = 1'b0;
    vectorIn      = '0;
    elementReady  = 1'b0;
    clearOverflow = 1'b0;

    // Reset and idle state
    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(elementValid), 32'd0);
    chk("rst_data",  32'(elementData),  32'd0);
    chk("rst_count", 32'(fifoCount),    32'd0);
    reset = 1'b1;
    idle(2, 1'b0);
    chk("idle_valid",    32'(elementValid), 32'd0);
    chk("idle_count",    32'(fifoCount),    32'd0);
    chk("idle_overflow", 32'(overflow),     32'd0);
    chk("idle_busy",     32'(busy),         32'd0);

    // Single vector, sink always ready, two-cycle latency
    beats = 0;
    send(16'h0000, 1'b1, 1'b1);
    idle(1, 1'b1);
    chk("lat_not_yet_valid", 32'(elementValid), 32'd0);
    idle(1, 1'b1);
    chk("lat_valid", 32'(elementValid), 32'd1);
    idle(5, 1'b1);
    idle(1, 1'b1);
    chk("t2_beats", 32'(beats), 32'd6);
    chk("t2_busy",  32'(busy),  32'd0);

    // Same vector with stalls 1,0,0,1,1,0,1,1
    beats = 0;
    send(16'h0000, 1'b1, 1'b1);
    idle(1, 1'b1);
    pat = 8'b1101_1001;
    for (int k = 0; k < 8; k++) cyc(pat[k], 1'b0, '0, 1'b0);
    drain(10);
    chk("t3_beats", 32'(beats), 32'd6);
    idle(1, 1'b1);
    chk("t3_busy", 32'(busy), 32'd0);

    // Back-to-back vectors with no bubble between them
    beats = 0;
    send(16'h00A0, 1'b1, 1'b1);
    send(16'h00B0, 1'b1, 1'b1);
    bubbles = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b0, '0, 1'b0);
      if (!elementValid) bubbles++;
    end
    chk("t4_bubbles", 32'(bubbles), 32'd0);
    chk("t4_beats",   32'(beats),   32'd12);
    idle(1, 1'b1);
    chk("t4_valid_after", 32'(elementValid), 32'd0);
    chk("t4_busy",        32'(busy),         32'd0);

    // Overflow: six vectors into a stalled sink, the sixth is dropped
    beats = 0;
    for (int v = 0; v < 6; v++) send(16'h0100 + 16'(v * 16), 1'b0, (v < 5));
    idle(1, 1'b0);
    chk("t5_count_full", 32'(fifoCount), 32'd4);
    chk("t5_overflow",   32'(overflow),  32'd1);
    chk("t5_busy",       32'(busy),      32'd1);
    cyc(1'b0, 1'b0, '0, 1'b1);
    idle(1, 1'b0);
    chk("t5_overflow_cleared", 32'(overflow), 32'd0);
    drain(60);
    chk("t5_beats", 32'(beats), 32'd30);
    idle(1, 1'b1);
    chk("t5_busy_end",  32'(busy),      32'd0);
    chk("t5_count_end", 32'(fifoCount), 32'd0);

    // Reset in the middle of a vector, then a fresh vector
    send(16'h0600, 1'b1, 1'b1);
    send(16'h0610, 1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc(1'b1, 1'b0, '0, 1'b0);
      if (elementValid && elementIndex == 3'd2) found = 1'b1;
    end
    chk("t6_reached_index2", 32'(found),     32'd1);
    chk("t6_count_before",   32'(fifoCount), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(elementValid), 32'd0);
    chk("t6_rst_count", 32'(fifoCount),    32'd0);
    chk("t6_rst_index", 32'(elementIndex), 32'd0);
    chk("t6_rst_data",  32'(elementData),  32'd0);
    chk("t6_rst_last",  32'(elementLast),  32'd0);
    chk("t6_rst_busy",  32'(busy),         32'd0);
    q.delete();
    @(negedge clock);
    reset = 1'b1;
    idle(1, 1'b0);
    chk("t6_post_valid", 32'(elementValid), 32'd0);
    beats = 0;
    send(16'h0700, 1'b1, 1'b1);
    drain(20);
    chk("t6_beats", 32'(beats), 32'd6);
    idle(1, 1'b1);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
